// File: rtl/remote_comm.sv
// remote_comm: sends cmd, data[15:8], data[7:0] as three 8N1 UART bytes, then waits for one response byte.
// Optional macro RESP_TIMEOUT_EN adds a response timeout of TIMEOUT_CYCLES clocks in WAIT_RESP.
module remote_comm #(
    parameter int BAUD_DIV       = 2604,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        RX,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp,
    output logic        timeout
);
    localparam int BAUD_W = $clog2(BAUD_DIV + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_DIV / 2);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [2:0] {IDLE, TX_CMD, TX_DHI, TX_DLO, WAIT_RESP} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cmd_buf_reg;
    logic [15:0] data_buf_reg;
    logic        cmd_sent_reg, cmd_sent_next;
    logic        resp_rdy_reg;
    logic [7:0]  resp_reg;
    logic        accept;
    logic        timeout_hit;

    assign accept = (state_reg == IDLE) && snd_cmd;

    // ---------------- transmitter ----------------
    logic                tx_load;
    logic [7:0]          tx_byte;
    logic [9:0]          tx_shift_reg;
    logic [BAUD_W-1:0]   tx_baud_reg;
    logic [3:0]          tx_bit_reg;
    logic                tx_active_reg;
    logic                tx_done;

    assign tx_done = tx_active_reg && (tx_baud_reg == BAUD_LAST) && (tx_bit_reg == 4'd9);

    // The frame is {stop, data, start}; shifting in ones leaves the line idling high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_reg  <= '1;
            tx_baud_reg   <= '0;
            tx_bit_reg    <= '0;
            tx_active_reg <= 1'b0;
        end else if (tx_load) begin
            tx_shift_reg  <= {1'b1, tx_byte, 1'b0};
            tx_baud_reg   <= '0;
            tx_bit_reg    <= '0;
            tx_active_reg <= 1'b1;
        end else if (tx_active_reg) begin
            if (tx_baud_reg == BAUD_LAST) begin
                tx_baud_reg  <= '0;
                tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
                if (tx_bit_reg == 4'd9) begin
                    tx_bit_reg    <= '0;
                    tx_active_reg <= 1'b0;
                end else begin
                    tx_bit_reg <= tx_bit_reg + 4'd1;
                end
            end else begin
                tx_baud_reg <= tx_baud_reg + BAUD_ONE;
            end
        end
    end

    assign TX = tx_shift_reg[0];

    // ---------------- receiver ----------------
    logic [1:0]          rx_sync_reg;
    logic                rx_prev_reg;
    logic                rx_active_reg;
    logic [BAUD_W-1:0]   rx_baud_reg;
    logic [3:0]          rx_bit_reg;
    logic [7:0]          rx_shift_reg;
    logic                rx_s;
    logic                rx_fall;
    logic                rx_sample;
    logic                rx_done;

    assign rx_s      = rx_sync_reg[1];
    assign rx_fall   = rx_prev_reg && !rx_s;
    assign rx_sample = rx_active_reg && (rx_baud_reg == BAUD_HALF);
    assign rx_done   = rx_sample && (rx_bit_reg == 4'd9) && rx_s;

    // Synchronizer and edge detector reset high so release of reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_reg <= 2'b11;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_sync_reg <= {rx_sync_reg[0], RX};
            rx_prev_reg <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_active_reg <= 1'b0;
            rx_baud_reg   <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
        end else if (!rx_active_reg) begin
            if (rx_fall) begin
                rx_active_reg <= 1'b1;
                rx_baud_reg   <= '0;
                rx_bit_reg    <= '0;
            end
        end else begin
            rx_baud_reg <= (rx_baud_reg == BAUD_LAST) ? '0 : rx_baud_reg + BAUD_ONE;
            if (rx_sample) begin
                rx_bit_reg <= rx_bit_reg + 4'd1;
                // A start bit that is high again at mid-bit was a glitch.
                if ((rx_bit_reg == 4'd0 && rx_s) || rx_bit_reg == 4'd9) begin
                    rx_active_reg <= 1'b0;
                end else if (rx_bit_reg != 4'd0) begin
                    rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
                end
            end
        end
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_next    = state_reg;
        tx_load       = 1'b0;
        tx_byte       = cmd_buf_reg;
        cmd_sent_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (snd_cmd) begin
                    tx_load    = 1'b1;
                    tx_byte    = cmd;
                    state_next = TX_CMD;
                end
            end
            TX_CMD: begin
                if (tx_done) begin
                    tx_load    = 1'b1;
                    tx_byte    = data_buf_reg[15:8];
                    state_next = TX_DHI;
                end
            end
            TX_DHI: begin
                if (tx_done) begin
                    tx_load    = 1'b1;
                    tx_byte    = data_buf_reg[7:0];
                    state_next = TX_DLO;
                end
            end
            TX_DLO: begin
                if (tx_done) begin
                    cmd_sent_next = 1'b1;
                    state_next    = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (rx_done || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cmd_buf_reg  <= '0;
            data_buf_reg <= '0;
            cmd_sent_reg <= 1'b0;
            resp_rdy_reg <= 1'b0;
            resp_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cmd_sent_reg <= cmd_sent_next;
            if (accept) begin
                cmd_buf_reg  <= cmd;
                data_buf_reg <= data;
            end
            if (rx_done) begin
                resp_reg <= rx_shift_reg;
            end
            // A new command wins over a byte completing in the same cycle.
            if (accept) begin
                resp_rdy_reg <= 1'b0;
            end else if (rx_done) begin
                resp_rdy_reg <= 1'b1;
            end
        end
    end

`ifdef RESP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            timeout_reg;

    assign timeout_hit = (state_reg == WAIT_RESP) && (to_cnt_reg == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= timeout_hit && !rx_done;
            if (state_reg == WAIT_RESP && !timeout_hit) begin
                to_cnt_reg <= to_cnt_reg + TO_ONE;
            end else begin
                to_cnt_reg <= '0;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign busy     = (state_reg != IDLE);
    assign cmd_sent = cmd_sent_reg;
    assign resp_rdy = resp_rdy_reg;
    assign resp     = resp_reg;

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: frames and response bytes are queued at stimulus time and
// checked by independent monitors decoding TX and watching resp_rdy.
`timescale 1ns/1ps
module tb_remote_comm;
    localparam int B    = 16;
    localparam int HALF = B / 2;
    localparam int TO   = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_cmd = 1'b0;
    logic [7:0]  cmd = '0;
    logic [15:0] data = '0;
    logic        RX = 1'b1;
    logic        TX, busy, cmd_sent, resp_rdy, timeout;
    logic [7:0]  resp;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_q[$];
    logic [7:0] resp_q[$];
    bit rst_event = 1'b0;

    remote_comm #(.BAUD_DIV(B), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
        .RX(RX), .TX(TX), .busy(busy), .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy), .resp(resp), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(negedge rst_n) rst_event = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bench UART receiver on TX; each decoded byte is compared with the expected frame queue.
    initial begin : tx_mon
        logic [7:0] b;
        bit bad;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && TX === 1'b0) begin
                rst_event = 1'b0;
                bad = 1'b0;
                repeat (HALF) @(negedge clk);
                if (TX !== 1'b0) bad = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    b[i] = TX;
                end
                repeat (B) @(negedge clk);
                if (TX !== 1'b1) bad = 1'b1;
                if (rst_event) begin
                    $display("tx byte discarded (reset during byte)");
                end else if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected_byte: got %02h expected no byte", b);
                end else begin
                    $display("tx byte %02h", b);
                    check("tx_byte", 32'(b), 32'(tx_q.pop_front()));
                    check("tx_framing", 32'(bad), 32'd0);
                end
            end
        end
    end

    // Response monitor: every rising resp_rdy must present the next expected response byte.
    initial begin : resp_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_rdy === 1'b1 && !prev) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got %02h expected no response", resp);
                end else begin
                    $display("resp byte %02h", resp);
                    check("resp", 32'(resp), 32'(resp_q.pop_front()));
                end
            end
            prev = resp_rdy;
        end
    end

    task automatic uart_send(input logic [7:0] b);
        $display("rx send %02h", b);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    task automatic push_frame(input logic [7:0] c, input logic [15:0] d);
        tx_q.push_back(c);
        tx_q.push_back(d[15:8]);
        tx_q.push_back(d[7:0]);
    endtask

    task automatic respond(input logic [7:0] r);
        resp_q.push_back(r);
        uart_send(r);
        check("resp_rdy_after_reply", 32'(resp_rdy), 32'd1);
        check("idle_after_reply", 32'(busy), 32'd0);
        check("resp_value_after_reply", 32'(resp), 32'(r));
    endtask

    // Issue one frame and follow it to cmd_sent; optionally poke snd_cmd while data[15:8] is on the line.
    task automatic run_frame(input logic [7:0] c, input logic [15:0] d, input bit inject);
        int cyc;
        int busy_low;
        int pulses;
        bit seen;
        @(negedge clk);
        snd_cmd = 1'b1;
        cmd = c;
        data = d;
        push_frame(c, d);
        $display("frame cmd=%02h data=%04h inject=%0d", c, d, inject);
        @(negedge clk);
        snd_cmd = 1'b0;
        cmd = 8'($urandom);
        data = 16'($urandom);
        cyc = 1;
        busy_low = 0;
        seen = 1'b0;
        while (!seen && cyc <= 40 * B) begin
            if (busy !== 1'b1) busy_low++;
            if (cmd_sent === 1'b1) begin
                seen = 1'b1;
            end else begin
                snd_cmd = (inject && cyc == 15 * B);
                if (snd_cmd) begin
                    cmd = ~c;
                    data = ~d;
                end
                @(negedge clk);
                cyc++;
            end
        end
        snd_cmd = 1'b0;
        check("cmd_sent_seen", 32'(seen), 32'd1);
        checks++;
        if (cyc < 30 * B - 3 || cyc > 30 * B + 3) begin
            errors++;
            $display("FAIL cmd_sent_latency: got %0d cycles expected %0d +-3", cyc, 30 * B);
        end
        check("busy_during_frame", 32'(busy_low), 32'd0);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (cmd_sent === 1'b1) pulses++;
        end
        check("cmd_sent_extra_pulses", 32'(pulses), 32'd0);
        check("tx_bytes_outstanding", 32'(tx_q.size()), 32'd0);
    endtask

    initial begin : stim
        logic [7:0]  c;
        logic [15:0] d;
        logic [7:0]  r;
        int n;
        int pulses;

        repeat (3) @(negedge clk);
        check("reset_TX", 32'(TX), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cmd_sent", 32'(cmd_sent), 32'd0);
        check("reset_resp_rdy", 32'(resp_rdy), 32'd0);
        check("reset_resp", 32'(resp), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_false_start_after_reset", 32'(resp_rdy), 32'd0);

        // Directed frame and reply.
        run_frame(8'h02, 16'h1234, 1'b0);
        respond(8'hA5);

        // snd_cmd during data[15:8] must be ignored.
        run_frame(8'($urandom), 16'($urandom), 1'b1);
        respond(8'($urandom));

        for (int k = 0; k < 3; k++) begin
            run_frame(8'($urandom), 16'($urandom), 1'b0);
            respond(8'($urandom));
        end

        // Reset in the middle of the third byte (an all-zero byte keeps TX low).
        @(negedge clk);
        snd_cmd = 1'b1;
        cmd = 8'h5A;
        data = 16'hC300;
        push_frame(8'h5A, 16'hC300);
        $display("frame cmd=5a data=c300 (reset mid third byte)");
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (25 * B - 1) @(negedge clk);
        check("tx_low_before_reset", 32'(TX), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_TX_high", 32'(TX), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_resp_rdy", 32'(resp_rdy), 32'd0);
        check("abort_resp", 32'(resp), 32'd0);
        tx_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12 * B) begin
            @(negedge clk);
            if (cmd_sent === 1'b1) pulses++;
        end
        check("no_cmd_sent_after_abort", 32'(pulses), 32'd0);
        run_frame(8'h77, 16'hBEEF, 1'b0);
        respond(8'h3C);

        // Reply byte completes on the same cycle snd_cmd is accepted: the clear wins.
        c = 8'($urandom);
        d = 16'($urandom);
        r = 8'($urandom);
        @(negedge clk);
        fork
            uart_send(r);
            begin
                repeat (3 + HALF + 9 * B) @(negedge clk);
                snd_cmd = 1'b1;
                cmd = c;
                data = d;
                push_frame(c, d);
                $display("frame cmd=%02h data=%04h (collides with reply)", c, d);
                @(negedge clk);
                snd_cmd = 1'b0;
                check("collision_resp_rdy_clear", 32'(resp_rdy), 32'd0);
                check("collision_busy", 32'(busy), 32'd1);
            end
        join
        n = 0;
        while (cmd_sent !== 1'b1 && n < 40 * B) begin
            @(negedge clk);
            n++;
        end
        check("collision_cmd_sent_seen", 32'(cmd_sent), 32'd1);
        repeat (2) @(negedge clk);
        check("collision_tx_bytes_outstanding", 32'(tx_q.size()), 32'd0);
        respond(8'($urandom));

        // No reply after a frame.
        run_frame(8'h10, 16'h0001, 1'b0);
`ifdef RESP_TIMEOUT_EN
        n = 4;
        while (timeout !== 1'b1 && n < TO + 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 32'(n), 32'(TO));
        check("timeout_idle", 32'(busy), 32'd0);
        check("timeout_resp_rdy", 32'(resp_rdy), 32'd0);
        @(negedge clk);
        check("timeout_single_pulse", 32'(timeout), 32'd0);
`else
        n = 0;
        repeat (TO + 200) begin
            @(negedge clk);
            if (timeout !== 1'b0) n++;
        end
        check("no_timeout_pulse", 32'(n), 32'd0);
        check("still_waiting_busy", 32'(busy), 32'd1);
        respond(8'h81);
`endif

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
